// File: rtl/matching_score_acc.sv
// matching_score_acc
//   Takes one point set (4 inner + 4 outer Q10.4 coordinates) per alpha step and
//   buffers it in a FIFO. For each set it reads the 8 pixels from frame memory and
//   forms diff = sum(outer) - sum(inner). Over one sweep it accumulates the diffs
//   into a saturating score and tracks the alpha index with the largest diff.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start               1-cycle pulse, (re)starts a sweep
//   pt_valid, new_*     point set input, lane k at [k*WIDTH +: WIDTH]
//   pix_rd, pix_addr    pixel read strobe / address (y*IMG_W + x)
//   pix_data            read data, one cycle after pix_rd
//   busy, done          sweep in progress / 1-cycle results-valid pulse
//   score, best_diff,   accumulated contrast, best per-alpha contrast and its
//   best_idx            alpha index
//   oor_cnt, fifo_ovf   out-of-range point count, sticky input-drop flag
module matching_score_acc #(
    parameter int WIDTH      = 14,
    parameter int IMG_W      = 320,
    parameter int IMG_H      = 240,
    parameter int ADDR_W     = 17,
    parameter int NUM_ALPHA  = 18,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 pt_valid,
    input  logic [4*WIDTH-1:0]   new_xi,
    input  logic [4*WIDTH-1:0]   new_yi,
    input  logic [4*WIDTH-1:0]   new_xo,
    input  logic [4*WIDTH-1:0]   new_yo,
    output logic                 pix_rd,
    output logic [ADDR_W-1:0]    pix_addr,
    input  logic [7:0]           pix_data,
    output logic                 busy,
    output logic [17:0]          score,
    output logic [10:0]          best_diff,
    output logic [4:0]           best_idx,
    output logic [7:0]           oor_cnt,
    output logic                 fifo_ovf,
    output logic                 done
);

    localparam int SW = 16 * WIDTH;          // coordinates of one set
    localparam int EW = SW + 5;              // plus alpha index
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(NUM_ALPHA + 1);
    localparam int IW = WIDTH - 4;           // integer part of a coordinate
    localparam logic [CW-1:0] NA   = CW'(NUM_ALPHA);
    localparam logic [PW:0]   FD   = (PW + 1)'(FIFO_DEPTH);
    localparam logic [IW-1:0] XLIM = IW'(IMG_W);
    localparam logic [IW-1:0] YLIM = IW'(IMG_H);
    localparam logic signed [18:0] SMAX = 19'sd131071;
    localparam logic signed [18:0] SMIN = -19'sd131071;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_FETCH, S_ACC, S_DONE} state_t;
    state_t state_q, state_d;

    logic [EW-1:0]        fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, rd_q;
    logic [PW:0]          cnt_q;
    logic [CW-1:0]        acc_q;             // sets accepted (incl. dropped)
    logic [EW-1:0]        set_q;             // set being fetched
    logic [3:0]           fc_q;              // fetch cycle 0..8
    logic                 rdv_q;             // read issued last cycle
    logic [9:0]           sum_in_q, sum_out_q;
    logic [ADDR_W-1:0]    addr_q;
    logic signed [17:0]   score_q;
    logic signed [10:0]   bdiff_q;
    logic [4:0]           bidx_q;
    logic [7:0]           oor_q;
    logic                 ovf_q, first_q;

    logic fifo_empty, fifo_full, all_acc, busy_w, take, push, pop;
    logic [WIDTH-1:0] px [8];
    logic [WIDTH-1:0] py [8];
    logic [WIDTH-1:0] pt_x, pt_y;
    logic [IW-1:0]    x_int, y_int;
    logic             fetch_rd, pt_oor;
    logic signed [10:0] diff_w;
    logic signed [18:0] ssum;
    logic signed [17:0] score_sat;

    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == FD);
    assign all_acc    = (acc_q == NA);
    assign busy_w     = (state_q == S_WAIT) || (state_q == S_FETCH) || (state_q == S_ACC);
    // Drops still consume an alpha index, so the count advances on take, not push.
    assign take = pt_valid && busy_w && !start && !all_acc;
    assign push = take && !fifo_full;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            S_WAIT, S_ACC: begin
                if (!fifo_empty) begin
                    state_d = S_FETCH;
                    pop     = 1'b1;
                end else if (all_acc) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_FETCH: if (fc_q == 4'd8) state_d = S_ACC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = state_q;
        endcase
        if (start) begin
            state_d = S_WAIT;
            pop     = 1'b0;
        end
    end

    // Point order in a fetch: inner lanes 0..3, then outer lanes 0..3.
    for (genvar k = 0; k < 4; k++) begin : g_pt
        assign px[k]   = set_q[k*WIDTH +: WIDTH];
        assign py[k]   = set_q[4*WIDTH + k*WIDTH +: WIDTH];
        assign px[k+4] = set_q[8*WIDTH + k*WIDTH +: WIDTH];
        assign py[k+4] = set_q[12*WIDTH + k*WIDTH +: WIDTH];
    end

    assign pt_x     = px[fc_q[2:0]];
    assign pt_y     = py[fc_q[2:0]];
    assign x_int    = pt_x[WIDTH-1:4];
    assign y_int    = pt_y[WIDTH-1:4];
    assign pt_oor   = (x_int >= XLIM) || (y_int >= YLIM);
    assign fetch_rd = (state_q == S_FETCH) && !fc_q[3];
    assign pix_rd   = fetch_rd && !pt_oor;
    assign pix_addr = pix_rd ? (ADDR_W'(y_int) * ADDR_W'(IMG_W) + ADDR_W'(x_int)) : addr_q;

    assign diff_w = $signed({1'b0, sum_out_q} - {1'b0, sum_in_q});

    always_comb begin
        ssum = 19'(score_q) + 19'(diff_w);
        if (ssum > SMAX)      score_sat = 18'sd131071;
        else if (ssum < SMIN) score_sat = -18'sd131071;
        else                  score_sat = ssum[17:0];
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_q] <= {5'(acc_q), new_yo, new_xo, new_yi, new_xi};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            wr_q      <= '0;
            rd_q      <= '0;
            cnt_q     <= '0;
            acc_q     <= '0;
            set_q     <= '0;
            fc_q      <= '0;
            rdv_q     <= 1'b0;
            sum_in_q  <= '0;
            sum_out_q <= '0;
            addr_q    <= '0;
            score_q   <= '0;
            bdiff_q   <= '0;
            bidx_q    <= '0;
            oor_q     <= '0;
            ovf_q     <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= pix_addr;
            rdv_q   <= pix_rd;
            if (start) begin
                wr_q    <= '0;
                rd_q    <= '0;
                cnt_q   <= '0;
                acc_q   <= '0;
                score_q <= '0;
                bdiff_q <= '0;
                bidx_q  <= '0;
                oor_q   <= '0;
                ovf_q   <= 1'b0;
                first_q <= 1'b1;
            end else begin
                if (take) begin
                    acc_q <= acc_q + 1'b1;
                    if (fifo_full) ovf_q <= 1'b1;
                end
                if (push) wr_q <= wr_q + 1'b1;
                cnt_q <= cnt_q + (PW + 1)'(push) - (PW + 1)'(pop);
                if (pop) begin
                    rd_q      <= rd_q + 1'b1;
                    set_q     <= fifo_mem[rd_q];
                    fc_q      <= '0;
                    sum_in_q  <= '0;
                    sum_out_q <= '0;
                end
                if (state_q == S_FETCH) begin
                    fc_q <= fc_q + 1'b1;
                    // Data returned in cycle c belongs to the point read in c-1.
                    if (fc_q != 4'd0 && rdv_q) begin
                        if (fc_q <= 4'd4) sum_in_q  <= sum_in_q  + 10'(pix_data);
                        else              sum_out_q <= sum_out_q + 10'(pix_data);
                    end
                    if (fetch_rd && pt_oor && oor_q != 8'hFF) oor_q <= oor_q + 1'b1;
                end
                if (state_q == S_ACC) begin
                    score_q <= score_sat;
                    if (first_q || diff_w > bdiff_q) begin
                        bdiff_q <= diff_w;
                        bidx_q  <= set_q[SW +: 5];
                        first_q <= 1'b0;
                    end
                end
            end
        end
    end

    assign busy      = busy_w;
    assign done      = (state_q == S_DONE);
    assign score     = score_q;
    assign best_diff = bdiff_q;
    assign best_idx  = bidx_q;
    assign oor_cnt   = oor_q;
    assign fifo_ovf  = ovf_q;

endmodule

// File: doc/matching_score_acc.md
Name: matching_score_acc

Overview:
Downstream consumer of the matching-point calculator. For each alpha step it takes one point set: 4 inner and 4 outer fixed-point coordinates. It fetches the 8 pixel intensities from the eye-image frame memory and forms a per-alpha contrast, defined as the sum of the outer pixels minus the sum of the inner pixels. It accumulates these contrasts over a full alpha sweep into a matching score and reports the alpha index with the strongest contrast.

Parameters:
WIDTH, 14, coordinate width (unsigned Q10.4, 4 fractional bits)
IMG_W, 320, image width in pixels
IMG_H, 240, image height in pixels
ADDR_W, 17, pixel memory address width
NUM_ALPHA, 18, point sets per sweep
FIFO_DEPTH, 32, input buffer depth in point sets (power of 2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  1-cycle pulse; begins a new sweep
pt_valid  in  1  point set valid this cycle
new_xi  in  4*WIDTH  inner x, lane k at [k*WIDTH +: WIDTH]
new_yi  in  4*WIDTH  inner y
new_xo  in  4*WIDTH  outer x
new_yo  in  4*WIDTH  outer y
pix_rd  out  1  pixel read strobe
pix_addr  out  ADDR_W  pixel address = y_int*IMG_W + x_int
pix_data  in  8  read data, valid exactly 1 cycle after pix_rd
busy  out  1  sweep in progress
score  out  18  signed accumulated contrast
best_diff  out  11  signed maximum per-alpha contrast
best_idx  out  5  alpha index of best_diff
oor_cnt  out  8  out-of-range point count for the sweep
fifo_ovf  out  1  sticky; a point set was dropped
done  out  1  1-cycle pulse; results valid

Behaviour:
- Reset: all outputs 0; FSM in IDLE; FIFO empty; all counters 0.
- The clock is clk. Reset is rst: synchronous, active-high, with priority over start.
- start: clears score, best_diff, best_idx, oor_cnt, fifo_ovf, input count and FIFO. Sets busy=1.
- start while busy: aborts the current sweep and restarts identically. No done pulse for the aborted sweep.
- Input acceptance:
  - pt_valid is pushed only while busy=1 and fewer than NUM_ALPHA sets have been accepted.
  - Otherwise pt_valid is ignored.
  - pt_valid in the same cycle as start is ignored.
- FIFO full with pt_valid: the set is dropped, fifo_ovf=1 (sticky), and the accepted count still increments.
- Index: the set at accept position n gets alpha index n (0..NUM_ALPHA-1). Dropped sets consume an index.
- FSM states: IDLE -> (start) WAIT -> (FIFO non-empty) FETCH -> ACC -> WAIT or DONE.
- FETCH, 9 cycles:
  - Cycles 0..7 issue reads in the order xi0/yi0..xi3/yi3, then xo0/yo0..xo3/yo3.
  - Cycles 1..8 capture pix_data.
  - pix_rd is asserted only in cycles 0..7.
- Coordinate conversion:
  - x_int = coord[WIDTH-1:4] (truncation).
  - A point is out of range if x_int >= IMG_W or y_int >= IMG_H. For such a point pix_rd=0, it contributes 0, and oor_cnt increments (saturates at 255).
  - When no read is issued, pix_addr holds its previous value.
- ACC, 1 cycle:
  - diff = sum_outer - sum_inner, 11-bit signed, range -1020..1020.
  - score += sign-extended diff, saturating at +/-131071.
  - best update when diff > best_diff (strict, so the first maximum wins) or for the first processed set.
- Sweep end:
  - Condition: NUM_ALPHA sets accepted, FIFO empty, and the last ACC is done.
  - Then enter DONE: done=1 for one cycle, busy=0, return to IDLE.
  - Results are held until the next start or rst.
- Sweep with all sets dropped: leave WAIT once NUM_ALPHA sets have been accepted and the FIFO is empty. done still pulses; best_idx=0, best_diff=0.
- Throughput: 10 cycles per set. A burst of 18 back-to-back sets fits in the FIFO with no drop when FIFO_DEPTH >= 18.
- Latency: done asserts 10 cycles after the ACC of the last set is entered from FETCH start, i.e. 10*NUM_ALPHA+1 cycles after the first accepted set for a back-to-back burst.

Test Plan:
1. Memory model with pixel = 100 inside the inner circle and 200 elsewhere. Start, then 18 back-to-back sets with all points in range. Expect diff = 400 per set, score = 7200, best_idx = 0 (tie rule), oor_cnt = 0. done occurs at cycle 181 after the first set.
2. Set 7 has outer pixels equal to 255 and all others are as in test 1. Expect best_diff = 620 and best_idx = 7.
3. xo0 = 14'h3FFF, giving x_int = 1023 which is >= IMG_W. Expect no pix_rd for that point, oor_cnt = 1 per such set, and a contribution of 0.
4. FIFO_DEPTH = 8 with 18 back-to-back sets. Expect fifo_ovf = 1, the dropped sets absent from score, and done still pulsing exactly once.
5. start asserted mid-FETCH of set 5. Expect the FIFO flushed, accumulators zeroed, no done pulse, and a new sweep that completes correctly.
6. rst asserted together with start, and rst asserted mid-sweep. Expect all outputs 0, IDLE state, and pt_valid ignored.
